// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file access sequencer.
package rf_pkg;

    localparam int unsigned W     = 16;
    localparam int unsigned NREGS = 8;
    localparam int unsigned IDXW  = $clog2(NREGS);

    typedef logic [IDXW-1:0] idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an enable; all-zero when disabled.
module onehot_dec
    import rf_pkg::*;
(
    input  logic [IDXW-1:0]  idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_access_seq.sv
// Read-execute-writeback sequencer in front of the tristate Reg16 cell bank.
// Define RF_R0_ZERO_EN to make index 0 a read-as-zero, write-ignored register.
module rf_access_seq
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDXW-1:0]  req_sa,
    input  logic [IDXW-1:0]  req_sb,
    input  logic [IDXW-1:0]  req_dst,
    input  logic             req_wr,
    output logic [NREGS-1:0] eA,
    output logic [NREGS-1:0] eB,
    input  logic [W-1:0]     busA,
    input  logic [W-1:0]     busB,
    output logic             op_valid,
    output logic [W-1:0]     opA,
    output logic [W-1:0]     opB,
    input  logic             res_valid,
    input  logic [W-1:0]     res_data,
    output logic [NREGS-1:0] ld,
    output logic [W-1:0]     wb_data
);

`ifdef RF_R0_ZERO_EN
    localparam bit R0Zero = 1'b1;
`else
    localparam bit R0Zero = 1'b0;
`endif

    state_e state_q;
    idx_t   sa_q;
    idx_t   sb_q;
    idx_t   dst_q;
    logic   wr_q;

    logic [NREGS-1:0] ea_dec;
    logic [NREGS-1:0] eb_dec;
    logic [NREGS-1:0] ld_dec;

    // Enables decode straight from the request so they are registered on acceptance.
    onehot_dec u_dec_a (
        .idx    (req_sa),
        .en     (!(R0Zero && (req_sa == '0))),
        .onehot (ea_dec)
    );

    onehot_dec u_dec_b (
        .idx    (req_sb),
        .en     (!(R0Zero && (req_sb == '0))),
        .onehot (eb_dec)
    );

    onehot_dec u_dec_ld (
        .idx    (dst_q),
        .en     (!(R0Zero && (dst_q == '0))),
        .onehot (ld_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            eA        <= '0;
            eB        <= '0;
            ld        <= '0;
            op_valid  <= 1'b0;
            opA       <= '0;
            opB       <= '0;
            wb_data   <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            dst_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        sa_q      <= req_sa;
                        sb_q      <= req_sb;
                        dst_q     <= req_dst;
                        wr_q      <= req_wr;
                        eA        <= ea_dec;
                        eB        <= eb_dec;
                        req_ready <= 1'b0;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    // An index-0 read under R0Zero has no driver, so ignore the floating bus.
                    opA      <= (R0Zero && (sa_q == '0)) ? '0 : busA;
                    opB      <= (R0Zero && (sb_q == '0)) ? '0 : busB;
                    eA       <= '0;
                    eB       <= '0;
                    op_valid <= 1'b1;
                    state_q  <= StExec;
                end
                StExec: begin
                    if (res_valid) begin
                        op_valid <= 1'b0;
                        if (wr_q) begin
                            wb_data <= res_data;
                            ld      <= ld_dec;
                            state_q <= StWrite;
                        end else begin
                            req_ready <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                StWrite: begin
                    ld        <= '0;
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_seq.sv
// Scoreboarded random bench for rf_access_seq with a behavioural register-file model.
module tb_rf_access_seq;
    import rf_pkg::*;

`ifdef RF_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [IDXW-1:0]  req_sa, req_sb, req_dst;
    logic             req_wr;
    logic [NREGS-1:0] eA, eB, ld;
    logic [W-1:0]     busA, busB;
    logic             op_valid;
    logic [W-1:0]     opA, opB;
    logic             res_valid;
    logic [W-1:0]     res_data;
    logic [W-1:0]     wb_data;

    always #5 clk = ~clk;

    rf_access_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sa    (req_sa),
        .req_sb    (req_sb),
        .req_dst   (req_dst),
        .req_wr    (req_wr),
        .eA        (eA),
        .eB        (eB),
        .busA      (busA),
        .busB      (busB),
        .op_valid  (op_valid),
        .opA       (opA),
        .opB       (opB),
        .res_valid (res_valid),
        .res_data  (res_data),
        .ld        (ld),
        .wb_data   (wb_data)
    );

    // Cell bank driven by the DUT's enables/loads; model is the bench's golden copy.
    logic [W-1:0] cells [NREGS];
    logic [W-1:0] model [NREGS];
    logic [W-1:0] junk;
    logic         load_cells = 1'b0;

    always_comb begin
        busA = junk;
        busB = ~junk;
        for (int i = 0; i < NREGS; i++) begin
            if (eA[i]) busA = cells[i];
            if (eB[i]) busB = cells[i];
        end
    end

    always @(posedge clk) begin
        junk <= W'($urandom);
        for (int i = 0; i < NREGS; i++) begin
            if (load_cells) cells[i] <= model[i];
            else if (ld[i]) cells[i] <= wb_data;
        end
    end

    typedef struct {
        logic [NREGS-1:0] ea;
        logic [NREGS-1:0] eb;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
    } rd_t;

    typedef struct {
        logic             wr;
        logic [NREGS-1:0] ld;
        logic [W-1:0]     d;
    } wb_t;

    rd_t rd_q[$];
    wb_t wb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents operands or a result handshake.
    logic             mon_en = 1'b0;
    logic             prev_opv = 1'b0;
    logic [NREGS-1:0] prev_ea = '0, prev_eb = '0;
    int               wb_stage = 0;
    wb_t              cur_wb;

    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot_eA", 32'($onehot0(eA)), 32'd1);
            check("onehot_eB", 32'($onehot0(eB)), 32'd1);
            check("onehot_ld", 32'($onehot0(ld)), 32'd1);
            if (op_valid && !prev_opv) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 32'(rd_q.size()), 32'd1);
                end else begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("read_eA", 32'(prev_ea), 32'(r.ea));
                    check("read_eB", 32'(prev_eb), 32'(r.eb));
                    check("opA", 32'(opA), 32'(r.a));
                    check("opB", 32'(opB), 32'(r.b));
                    check("ready_busy", 32'(req_ready), 32'd0);
                end
            end
            if (op_valid) check("exec_enables_off", 32'(eA | eB), 32'd0);
            if (wb_stage == 1) begin
                check("op_valid_drop", 32'(op_valid), 32'd0);
                check("ld_write", 32'(ld), 32'(cur_wb.ld));
                check("ready_after_res", 32'(req_ready), 32'(!cur_wb.wr));
                if (cur_wb.wr) check("wb_data", 32'(wb_data), 32'(cur_wb.d));
                wb_stage = cur_wb.wr ? 2 : 0;
            end else if (wb_stage == 2) begin
                check("ld_clear", 32'(ld), 32'd0);
                check("ready_after_wb", 32'(req_ready), 32'd1);
                wb_stage = 0;
            end else begin
                check("ld_idle", 32'(ld), 32'd0);
            end
            if (res_valid && op_valid) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_result", 32'(wb_q.size()), 32'd1);
                end else begin
                    cur_wb   = wb_q.pop_front();
                    wb_stage = 1;
                end
            end
        end
        prev_opv = op_valid;
        prev_ea  = eA;
        prev_eb  = eB;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(req_ready), 32'd1);
    endtask

    task automatic load_model();
        load_cells = 1'b1;
        tick();
        load_cells = 1'b0;
    endtask

    task automatic do_txn(input idx_t sa, input idx_t sb, input idx_t dst, input logic wr,
                          input logic [W-1:0] res, input int dly, input logic noise);
        rd_t r;
        wb_t w;
        wait_ready("accept_timeout");
        req_valid = 1'b1;
        req_sa    = sa;
        req_sb    = sb;
        req_dst   = dst;
        req_wr    = wr;
        res_valid = noise;
        res_data  = W'($urandom);
        r.ea = (R0 && sa == 0) ? '0 : (NREGS'(1) << sa);
        r.eb = (R0 && sb == 0) ? '0 : (NREGS'(1) << sb);
        r.a  = (R0 && sa == 0) ? '0 : model[sa];
        r.b  = (R0 && sb == 0) ? '0 : model[sb];
        rd_q.push_back(r);
        tick();
        // READ: stray result and a fresh request must both be ignored.
        res_valid = noise;
        req_sa    = idx_t'($urandom);
        req_dst   = idx_t'($urandom);
        req_wr    = ~wr;
        tick();
        res_valid = 1'b0;
        repeat (dly) tick();
        res_valid = 1'b1;
        res_data  = res;
        req_valid = 1'b0;
        w.wr = wr;
        w.d  = res;
        w.ld = (wr && !(R0 && dst == 0)) ? (NREGS'(1) << dst) : '0;
        wb_q.push_back(w);
        if (wr && !(R0 && dst == 0)) model[dst] = res;
        tick();
        res_valid = 1'b0;
        wait_ready("complete_timeout");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_sa    = '0;
        req_sb    = '0;
        req_dst   = '0;
        req_wr    = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        for (int i = 0; i < NREGS; i++) model[i] = W'($urandom);
        load_cells = 1'b1;
        repeat (2) tick();
        load_cells = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_en", 32'({eA, eB, ld}), 32'd0);
        check("rst_opv", 32'(op_valid), 32'd0);
        check("rst_ops", 32'({opA, opB}), 32'd0);
        check("rst_wb", 32'(wb_data), 32'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of EXEC.
        model[2] = 16'h1234;
        load_model();
        req_valid = 1'b1;
        req_sa    = 3'd2;
        req_sb    = 3'd2;
        req_dst   = 3'd4;
        req_wr    = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_opv", 32'(op_valid), 32'd1);
        check("pre_rst_opA", 32'(opA), 32'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_opv", 32'(op_valid), 32'd0);
        check("mid_rst_ops", 32'({opA, opB}), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_en", 32'({eA, eB, ld}), 32'd0);
        tick();
        mon_en = 1'b1;

        model[2] = 16'hBEEF;
        model[5] = 16'h0042;
        load_model();
        do_txn(3'd2, 3'd5, 3'd3, 1'b1, 16'hBF31, 0, 1'b1);
        do_txn(3'd1, 3'd1, 3'd1, 1'b1, 16'h5A5A, 1, 1'b0);
        do_txn(3'd1, 3'd1, 3'd6, 1'b0, 16'h7777, 0, 1'b1);
        do_txn(3'd0, 3'd0, 3'd0, 1'b1, 16'hC0DE, 2, 1'b0);
        do_txn(3'd0, 3'd7, 3'd0, 1'b1, 16'h1111, 0, 1'b1);
        for (int t = 0; t < 40; t++) begin
            do_txn(idx_t'($urandom), idx_t'($urandom), idx_t'($urandom),
                   1'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end
        repeat (3) tick();
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("wb_q_empty", 32'(wb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
